alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Parametrised, handshaked integer execution unit for the OoO back end. Accepts one op per
//   issue from the reservation station, produces a tagged result for the CDB/ROB writeback.
//   Single-cycle ALU ops return after 1 cycle; optional iterative MUL/DIV ops take WIDTH+1 cycles.
// PARAMETERS
//   WIDTH   32  operand/result width; power of two, >=8; shift amount = op2[$clog2(WIDTH)-1:0]
//   TAG_W   6   ROB tag width, passed through unchanged
// PORTS
//   clk         in   1        clock, all state on rising edge
//   rst         in   1        synchronous, active-high reset
//   flush       in   1        sync kill of in-flight op and held result (branch mispredict)
//   in_valid    in   1        issue request
//   in_ready    out  1        unit can accept; transfer = in_valid & in_ready
//   in_op1      in   WIDTH    operand 1
//   in_op2      in   WIDTH    operand 2
//   in_func     in   4        `ALU_OP_* code from PARAM.vh
//   in_tag      in   TAG_W    ROB tag of the op
//   out_valid   out  1        result held and valid
//   out_ready   in   1        consumer accepts; transfer = out_valid & out_ready
//   out_result  out  WIDTH    result
//   out_tag     out  TAG_W    tag of the result
//   busy        out  1        iterative op in progress (state BUSY)
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, out_result=0, out_tag=0, busy=0, counters 0.
//   - in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush (combinational).
//   - Single-cycle ops: ADD SUB AND OR XOR SLT(signed) SLTU SLL, SRL logical, SRA arithmetic
//     (sign-fill). Undefined func -> result 0. Result registered: out_valid rises cycle after accept.
//   - Output register holds result/tag stable while out_valid & ~out_ready; updates on accept only.
//   - Back-to-back: accept in same cycle output drains -> 1 result/cycle throughput.
//   - FSM (ALU_MULDIV_EN only): IDLE -> BUSY on accept of MUL/MULHU/DIV/DIVU/REM/REMU;
//     BUSY iterates WIDTH cycles (shift-add multiply / restoring divide, 1 bit per cycle);
//     BUSY -> DONE after last iteration; DONE loads output register (out_valid next) -> IDLE.
//     Accept-to-out_valid latency = WIDTH+1 cycles. in_ready=0 in BUSY and DONE.
//   - MUL = low WIDTH bits of product; MULHU = high WIDTH bits, unsigned x unsigned.
//   - DIV/REM signed: divide magnitudes, quotient negated if signs differ, remainder takes
//     dividend's sign. Divide by zero: quotient all ones, remainder = op1.
//     Signed overflow (op1=MIN, op2=-1): quotient = MIN, remainder = 0. No exceptions raised.
//   - flush: next edge state=IDLE, out_valid=0, busy=0; in_ready forced 0 during flush cycle,
//     so an op presented with flush is dropped. flush beats completion in the same cycle.
//   - rst mid-operation: identical to flush plus out_result/out_tag cleared.
//   - out_valid & out_ready while FSM in DONE: drain and load happen same edge, no bubble.
// CONFIGURATION
//   ALU_MULDIV_EN defined: MUL/DIV datapath, FSM and busy logic built as above.
//   Not defined: no FSM; muldiv func codes fall to default (result 0, latency 1); busy tied 0.
// TESTING
//   1. ADD 0x7FFFFFFF+1, tag 5, out_ready=1 -> next cycle out_valid=1, result 0x80000000, tag 5.
//   2. SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; shift by 33 uses amount 1.
//   3. out_ready=0 for 3 cycles after SUB 3-5 -> result 0xFFFFFFFE held stable, in_ready=0.
//   4. DIV -7/2 -> out_valid at accept+33, quotient 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF;
//      DIVU 5/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//   5. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same -> 0x00000001; busy=1 during BUSY.
//   6. flush at BUSY cycle 10 of DIV -> next cycle busy=0, out_valid never rises, in_ready=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Handshaked integer execution unit: single-cycle ALU ops plus optional iterative MUL/DIV.
// Build with ALU_MULDIV_EN defined to include the multiply/divide datapath and its FSM.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [3:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Handshake: a transfer happens on any edge where valid & ready are both high;
  // valid never waits on ready, and the output register only changes on a drain or a load.

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  logic             accept;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic             ld_alu;
  logic             ld_fin;
  logic [WIDTH-1:0] fin_res;
  logic [TAG_W-1:0] fin_tag;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign accept = in_valid & in_ready;
  assign shamt  = in_op2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (in_func)
      OP_ADD:  alu_res = in_op1 + in_op2;
      OP_SUB:  alu_res = in_op1 - in_op2;
      OP_AND:  alu_res = in_op1 & in_op2;
      OP_OR:   alu_res = in_op1 | in_op2;
      OP_XOR:  alu_res = in_op1 ^ in_op2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_op1 < in_op2};
      OP_SLL:  alu_res = in_op1 << shamt;
      OP_SRL:  alu_res = in_op1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_op1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [3:0]       func_q, func_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;

  logic             in_is_muldiv, in_is_mul, in_is_signed, op1_neg, op2_neg;
  logic             step_mul;
  logic [WIDTH-1:0] step_hi, step_lo, step_opnd, nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  assign in_is_muldiv = in_func inside {OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign in_is_mul    = in_func inside {OP_MUL, OP_MULHU};
  assign in_is_signed = in_func inside {OP_DIV, OP_REM};
  assign op1_neg      = in_is_signed & in_op1[WIDTH-1];
  assign op2_neg      = in_is_signed & in_op2[WIDTH-1];

  // The accept edge already performs the first iteration straight from the issue
  // operands, which keeps accept-to-valid at WIDTH+1 including the DONE load.
  always_comb begin
    if (state_q == ST_IDLE) begin
      step_mul  = in_is_mul;
      step_hi   = '0;
      step_lo   = op1_neg ? -in_op1 : in_op1;
      step_opnd = op2_neg ? -in_op2 : in_op2;
    end else begin
      step_mul  = func_q inside {OP_MUL, OP_MULHU};
      step_hi   = hi_q;
      step_lo   = lo_q;
      step_opnd = opnd_q;
    end
  end

  // Multiply: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
  // Divide: {hi,lo} shifts left, restoring when the trial subtraction borrows.
  always_comb begin
    mul_sum   = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_opnd} : {(WIDTH+1){1'b0}});
    div_shift = {step_hi, step_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, step_opnd};
    if (step_mul) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], step_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      nxt_lo = {step_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_comb begin
    fin_res = '0;
    case (func_q)
      OP_MUL:          fin_res = lo_q;
      OP_MULHU:        fin_res = hi_q;
      OP_DIV, OP_DIVU: fin_res = neg_q ? -lo_q : lo_q;
      OP_REM, OP_REMU: fin_res = rneg_q ? -hi_q : hi_q;
      default:         fin_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_is_muldiv) begin
          state_d = ST_BUSY;
          hi_d    = nxt_hi;
          lo_d    = nxt_lo;
          opnd_d  = step_opnd;
          cnt_d   = SH_W'(1);
          func_d  = in_func;
          tag_d   = in_tag;
          // A zero divisor keeps the unsigned all-ones quotient, so no negation then.
          neg_d   = (op1_neg ^ op2_neg) & (in_op2 != '0);
          rneg_d  = op1_neg;
        end
      end
      ST_BUSY: begin
        hi_d  = nxt_hi;
        lo_d  = nxt_lo;
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(WIDTH-1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE) & (~out_valid_q | out_ready) & ~flush;
  assign busy     = (state_q == ST_BUSY);
  assign ld_alu   = accept & ~in_is_muldiv;
  assign ld_fin   = (state_q == ST_DONE) & ~flush;
  assign fin_tag  = tag_q;
`else
  assign in_ready = (~out_valid_q | out_ready) & ~flush;
  assign busy     = 1'b0;
  assign ld_alu   = accept;
  assign ld_fin   = 1'b0;
  assign fin_res  = '0;
  assign fin_tag  = '0;
`endif

  always_comb begin
    out_valid_d  = out_valid_q & ~out_ready;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (ld_alu) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_res;
      out_tag_d    = in_tag;
    end
    if (ld_fin) begin
      out_valid_d  = 1'b1;
      out_result_d = fin_res;
      out_tag_d    = fin_tag;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed steps plus random ops checked against an arithmetic model.
module tb_alu_exec_unit;
  localparam int W  = 32;
  localparam int TW = 6;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [3:0] F_ADD = 4'd0,  F_SUB = 4'd1,  F_AND = 4'd2,   F_OR = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4,  F_SLT = 4'd5,  F_SLTU = 4'd6,  F_SLL = 4'd7;
  localparam logic [3:0] F_SRL = 4'd8,  F_SRA = 4'd9,  F_MUL = 4'd10,  F_MULHU = 4'd11;
  localparam logic [3:0] F_DIV = 4'd12, F_DIVU = 4'd13, F_REM = 4'd14, F_REMU = 4'd15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_op1 = '0;
  logic [W-1:0]  in_op2 = '0;
  logic [3:0]    in_func = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          busy;

  int passed = 0;
  int total  = 0;

  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] exp_tag_q[$];
  int            exp_lat_q[$];

  alu_exec_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_func(in_func), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [W-1:0] ref_result(input logic [3:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (f)
      F_ADD:  return a + b;
      F_SUB:  return a - b;
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_XOR:  return a ^ b;
      F_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F_SLTU: return (a < b) ? 32'd1 : 32'd0;
      F_SLL:  return a << b[4:0];
      F_SRL:  return a >> b[4:0];
      F_SRA:  return 32'($signed(a) >>> b[4:0]);
`ifdef ALU_MULDIV_EN
      F_MUL:   return p[31:0];
      F_MULHU: return p[63:32];
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      F_REMU: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] f);
    return (MD_EN && f >= F_MUL) ? W + 1 : 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // driver: starts and ends just after a rising edge
  task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1; in_func = f; in_op1 = a; in_op2 = b; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    exp_q.push_back(ref_result(f, a, b));
    exp_tag_q.push_back(t);
    exp_lat_q.push_back(ref_latency(f));
  endtask

  task automatic collect(input string name);
    int lat;
    logic busy_seen;
    lat = 0;
    busy_seen = 1'b0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      busy_seen = busy_seen | busy;
    end while (!out_valid && lat < 100);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat_q[0]));
    check({name, "_res"}, {32'b0, out_result}, {32'b0, exp_q.pop_front()});
    check({name, "_tag"}, {58'b0, out_tag}, {58'b0, exp_tag_q.pop_front()});
    check({name, "_busy"}, {63'b0, busy_seen}, {63'b0, (exp_lat_q.pop_front() > 1)});
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [3:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t);
    issue(f, a, b, t);
    collect(name);
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ea, eb;
    logic [3:0] ef;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_result", {32'b0, out_result}, 64'd0);
    check("rst_out_tag", {58'b0, out_tag}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // single-cycle ops and shift boundaries
    run_op("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'd1, 6'd5);
    run_op("sra4", F_SRA, 32'h8000_0000, 32'd4, 6'd1);
    run_op("srl4", F_SRL, 32'h8000_0000, 32'd4, 6'd2);
    run_op("sll33", F_SLL, 32'h0000_0003, 32'd33, 6'd3);
    run_op("slt_neg", F_SLT, 32'hFFFF_FFFF, 32'd1, 6'd4);
    run_op("sltu_neg", F_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd6);

    // output held under backpressure
    issue(F_SUB, 32'd3, 32'd5, 6'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      check("hold_res", {32'b0, out_result}, {32'b0, exp_q[0]});
      check("hold_tag", {58'b0, out_tag}, {58'b0, exp_tag_q[0]});
      check("hold_in_ready", {63'b0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", {63'b0, out_valid}, 64'd1);
    check("hold_release_ready", {63'b0, in_ready}, 64'd1);
    void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); void'(exp_lat_q.pop_front());
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_drained", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // back-to-back throughput
    for (int i = 0; i < 6; i++) begin
      ef = 4'($urandom_range(0, 9));
      ea = pick_operand();
      eb = pick_operand();
      in_valid = 1'b1; in_func = ef; in_op1 = ea; in_op2 = eb; in_tag = TW'(i + 20);
      @(negedge clk);
      check("b2b_ready", {63'b0, in_ready}, 64'd1);
      if (i > 0) begin
        check("b2b_valid", {63'b0, out_valid}, 64'd1);
        check("b2b_res", {32'b0, out_result}, {32'b0, exp_q.pop_front()});
        check("b2b_tag", {58'b0, out_tag}, {58'b0, exp_tag_q.pop_front()});
      end
      exp_q.push_back(ref_result(ef, ea, eb));
      exp_tag_q.push_back(TW'(i + 20));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_res", {32'b0, out_result}, {32'b0, exp_q.pop_front()});
    check("b2b_last_tag", {58'b0, out_tag}, {58'b0, exp_tag_q.pop_front()});
    @(posedge clk);
    #1;

    // iterative ops and their corner cases
    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 6'd10);
    run_op("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2, 6'd11);
    run_op("divu_zero", F_DIVU, 32'd5, 32'd0, 6'd12);
    run_op("div_zero", F_DIV, 32'hFFFF_FFF9, 32'd0, 6'd13);
    run_op("rem_zero", F_REM, 32'hFFFF_FFF9, 32'd0, 6'd14);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16);
    run_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd17);
    run_op("mul_max", F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd18);
    run_op("remu", F_REMU, 32'd1000, 32'd7, 6'd19);

    // flush during an iterative op
    issue(F_DIV, 32'd1000, 32'd3, 6'd30);
    void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); void'(exp_lat_q.pop_front());
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_ready_after", {63'b0, in_ready}, 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_result", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;

    // op presented together with flush is dropped
    in_valid = 1'b1; in_func = F_ADD; in_op1 = 32'd1; in_op2 = 32'd2; in_tag = 6'd31;
    flush = 1'b1;
    @(negedge clk);
    check("flush_drop_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", {63'b0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of an operation
    issue(F_MUL, 32'd12345, 32'd678, 6'd33);
    void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); void'(exp_lat_q.pop_front());
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_res", {32'b0, out_result}, 64'd0);
    check("mid_rst_tag", {58'b0, out_tag}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // random ops over every function code
    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
             TW'($urandom_range(0, 63)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
